uart_tx_frame_seq: RTL and testbench

- Parametrised UART transmit frame sequencer; successor to the fixed 4:1 start/data/parity/stop bit selector.
- Accepts one parallel word per handshake and serialises it on tx_out, paced by an external one-cycle baud_tick strobe (one tick per bit period).
- Frame is start bit, DATA_BITS data bits sent LSB first, an optional parity bit, then STOP_BITS stop bits.
- Sits between the TX holding logic and the baud generator; exports the current field select for debug and compatibility.

---
 rtl/uart_tx_frame_seq.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_frame_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_seq.sv
// rtl/uart_tx_frame_seq.sv - UART transmit frame sequencer (start/data/parity/stop)
//
// Serialises one parallel word per tx_valid/tx_ready handshake onto tx_out,
// paced by a one-cycle baud_tick strobe per bit period. The frame is a start
// bit, DATA_BITS data bits (LSB first), an optional parity bit and STOP_BITS
// stop bits.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   baud_tick  one-cycle strobe at each bit-period boundary
//   tx_data    word to transmit, sampled only at accept
//   tx_valid   tx_data is valid
//   tx_ready   block can accept a word (registered)
//   tx_out     serial line, registered, idles high
//   busy       a frame is in progress (registered)
//   sel        current field: 00 start, 01 data, 10 parity, 11 stop/idle
module uart_tx_frame_seq #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic [1:0]           sel
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame_seq: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame_seq: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_IDLE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q, busy_d;
  logic [1:0]           sel_q, sel_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // A tick coincident with accept is deliberately not seen: ARM only
        // starts looking for ticks from the following cycle.
        if (tx_valid && tx_ready_q) begin
          shift_d    = tx_data;
          par_d      = (^tx_data) ^ PAR_ODD;
          bit_idx_d  = 4'd0;
          stop_cnt_d = 1'b0;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        if (baud_tick) state_d = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          bit_idx_d = 4'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == LAST_IDX) begin
            stop_cnt_d = 1'b0;
            state_d    = PAR_EN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) state_d = S_IDLE;
          else                         stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so the registered line moves
    // on the same edge that samples the causing baud_tick.
    tx_out_d = 1'b1;
    sel_d    = SEL_IDLE;
    unique case (state_d)
      S_START: begin
        tx_out_d = 1'b0;
        sel_d    = SEL_START;
      end
      S_DATA: begin
        tx_out_d = shift_d[0];
        sel_d    = SEL_DATA;
      end
      S_PARITY: begin
        tx_out_d = par_d;
        sel_d    = SEL_PARITY;
      end
      default: begin
        tx_out_d = 1'b1;
        sel_d    = SEL_IDLE;
      end
    endcase
    busy_d     = (state_d != S_IDLE);
    tx_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= 4'd0;
      stop_cnt_q <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      sel_q      <= SEL_IDLE;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      sel_q      <= sel_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_uart_tx_frame_seq.sv
// tb/tb_uart_tx_frame_seq.sv - self-checking bench for uart_tx_frame_seq
module tb_uart_tx_frame_seq;

  // Four configurations share one stimulus stream: 8N1, 8E1, 8O1, 5E2.
  localparam int DB_K [4] = '{8, 8, 8, 5};
  localparam int PE_K [4] = '{0, 1, 1, 1};
  localparam int PO_K [4] = '{0, 0, 1, 0};
  localparam int SB_K [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic       tx_valid;
  logic [7:0] tx_data;

  logic [3:0]      o_tx, o_rdy, o_busy;
  logic [3:0][1:0] o_sel;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame_seq #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(o_rdy[0]), .tx_out(o_tx[0]), .busy(o_busy[0]), .sel(o_sel[0]));
  uart_tx_frame_seq #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) d1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(o_rdy[1]), .tx_out(o_tx[1]), .busy(o_busy[1]), .sel(o_sel[1]));
  uart_tx_frame_seq #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) d2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(o_rdy[2]), .tx_out(o_tx[2]), .busy(o_busy[2]), .sel(o_sel[2]));
  uart_tx_frame_seq #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) d3 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(tx_data[4:0]), .tx_valid(tx_valid),
    .tx_ready(o_rdy[3]), .tx_out(o_tx[3]), .busy(o_busy[3]), .sel(o_sel[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: on accept the whole frame is laid out as a list of (bit, sel)
  // fields; each tick shows the next field, and one tick past the end of the
  // list the line is idle and ready again.
  logic       m_busy [4];
  logic       m_rdy  [4];
  logic       m_tx   [4];
  logic [1:0] m_sel  [4];
  logic       fq_bit [4][16];
  logic [1:0] fq_sel [4][16];
  int         fq_len [4];
  int         fq_pos [4];

  initial begin
    int   n;
    logic p;
    for (int k = 0; k < 4; k++) begin
      m_busy[k] = 1'b0; m_rdy[k] = 1'b1; m_tx[k] = 1'b1; m_sel[k] = 2'b11;
      fq_len[k] = 0; fq_pos[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 4; k++) begin
        if (!rst_n) begin
          m_busy[k] = 1'b0; m_rdy[k] = 1'b1; m_tx[k] = 1'b1; m_sel[k] = 2'b11;
          fq_len[k] = 0; fq_pos[k] = 0;
        end else if (!m_busy[k]) begin
          if (tx_valid && m_rdy[k]) begin
            n = 0; p = 1'b0;
            fq_bit[k][n] = 1'b0; fq_sel[k][n] = 2'b00; n++;
            for (int i = 0; i < DB_K[k]; i++) begin
              fq_bit[k][n] = tx_data[i]; fq_sel[k][n] = 2'b01; n++;
              p = p ^ tx_data[i];
            end
            if (PE_K[k] != 0) begin
              fq_bit[k][n] = p ^ (PO_K[k] != 0); fq_sel[k][n] = 2'b10; n++;
            end
            for (int s = 0; s < SB_K[k]; s++) begin
              fq_bit[k][n] = 1'b1; fq_sel[k][n] = 2'b11; n++;
            end
            fq_len[k] = n; fq_pos[k] = 0;
            m_busy[k] = 1'b1; m_rdy[k] = 1'b0;
          end
        end else if (baud_tick) begin
          if (fq_pos[k] < fq_len[k]) begin
            m_tx[k]  = fq_bit[k][fq_pos[k]];
            m_sel[k] = fq_sel[k][fq_pos[k]];
            fq_pos[k]++;
          end else begin
            m_busy[k] = 1'b0; m_rdy[k] = 1'b1; m_tx[k] = 1'b1; m_sel[k] = 2'b11;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("d%0d tx_out", k),   o_tx[k],   m_tx[k]);
        chk($sformatf("d%0d sel", k),      o_sel[k],  m_sel[k]);
        chk($sformatf("d%0d busy", k),     o_busy[k], m_busy[k]);
        chk($sformatf("d%0d tx_ready", k), o_rdy[k],  m_rdy[k]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Per-tick log of outputs sampled just after each tick edge.
  logic       lg_tx  [4][32];
  logic [1:0] lg_sel [4][32];
  logic       lg_rdy [4][32];

  task automatic cyc(input logic v, input logic tk);
    tx_valid  = v;
    baud_tick = tk;
    @(posedge clk);
    #2;
  endtask

  task automatic run_ticks(input int nt, input int inj_at, input logic [7:0] inj_d, input logic hold_v);
    logic tk, v;
    for (int c = 0; c < 16 * nt; c++) begin
      tk = (c % 16 == 15);
      v  = hold_v || (c == inj_at);
      if (c == inj_at) tx_data = inj_d;
      cyc(v, tk);
      if (c == inj_at) chk("tx_valid ignored while busy", o_rdy[0], 1'b0);
      if (tk) begin
        for (int k = 0; k < 4; k++) begin
          lg_tx[k][c/16]  = o_tx[k];
          lg_sel[k][c/16] = o_sel[k];
          lg_rdy[k][c/16] = o_rdy[k];
        end
      end
    end
  endtask

  task automatic wait_idle();
    int budget = 1000;
    while (o_rdy != 4'hF && budget > 0) begin
      cyc(1'b0, 1'b0);
      budget--;
    end
    chk("wait_idle all ready", o_rdy, 4'hF);
  endtask

  task automatic send(input logic [7:0] d);
    wait_idle();
    tx_data = d;
    cyc(1'b1, 1'b0);
  endtask

  initial begin
    logic [9:0] v10;
    logic [4:0] v5;
    int         cnt;

    rst_n = 1'b0; tx_valid = 1'b0; baud_tick = 1'b0; tx_data = 8'h00;
    repeat (3) cyc(1'b0, 1'b0);
    chk("reset tx_out", o_tx[0], 1'b1);
    chk("reset tx_ready", o_rdy[0], 1'b1);
    chk("reset busy", o_busy[0], 1'b0);
    chk("reset sel", o_sel[0], 2'b11);
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);

    // 0x55: 8N1 line pattern and sel sequence
    send(8'h55);
    chk("accept drops tx_ready", o_rdy[0], 1'b0);
    run_ticks(12, -1, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) v10[i] = lg_tx[0][i];
    chk("8N1 0x55 line bits", v10, 10'b1010101010);
    chk("8N1 start sel", lg_sel[0][0], 2'b00);
    cnt = 0;
    for (int i = 1; i <= 8; i++) if (lg_sel[0][i] == 2'b01) cnt++;
    chk("8N1 data sel count", cnt, 8);
    chk("8N1 stop sel", lg_sel[0][9], 2'b11);
    chk("8N1 ready low at stop", lg_rdy[0][9], 1'b0);
    chk("8N1 ready after final tick", lg_rdy[0][10], 1'b1);

    // 0x07: parity even=1, odd=0
    send(8'h07);
    run_ticks(12, -1, 8'h00, 1'b0);
    chk("8E1 0x07 parity bit", lg_tx[1][9], 1'b1);
    chk("8E1 parity sel", lg_sel[1][9], 2'b10);
    chk("8O1 0x07 parity bit", lg_tx[2][9], 1'b0);
    chk("8E1 stop bit", lg_tx[1][10], 1'b1);
    chk("8E1 ready low at stop", lg_rdy[1][10], 1'b0);
    chk("8E1 ready after final tick", lg_rdy[1][11], 1'b1);

    // 0x00: even parity 0, odd parity 1
    send(8'h00);
    run_ticks(12, -1, 8'h00, 1'b0);
    chk("8E1 0x00 parity bit", lg_tx[1][9], 1'b0);
    chk("8O1 0x00 parity bit", lg_tx[2][9], 1'b1);

    // 0x1F on 5E2: five ones, parity 1, two stop periods
    send(8'h1F);
    run_ticks(12, -1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) v5[i] = lg_tx[3][i+1];
    chk("5E2 data bits", v5, 5'b11111);
    chk("5E2 parity bit", lg_tx[3][6], 1'b1);
    chk("5E2 parity sel", lg_sel[3][6], 2'b10);
    chk("5E2 stop bit", lg_tx[3][7], 1'b1);
    chk("5E2 second stop period", lg_tx[3][8], 1'b1);
    chk("5E2 ready low after 1st stop tick", lg_rdy[3][8], 1'b0);
    chk("5E2 ready after 2nd stop tick", lg_rdy[3][9], 1'b1);

    // 0x3C with 0xAA pulsed mid-data; tx_data stays 0xAA afterwards
    send(8'h3C);
    run_ticks(12, 16 * 4 + 5, 8'hAA, 1'b0);
    for (int i = 0; i < 10; i++) v10[i] = lg_tx[0][i];
    chk("8N1 0x3C line bits", v10, 10'b1001111000);
    repeat (4) cyc(1'b0, 1'b0);
    chk("0xAA not accepted", o_busy[0], 1'b0);

    // Asynchronous reset in the middle of data bit 3
    send(8'h55);
    run_ticks(5, -1, 8'h00, 1'b0);
    repeat (7) cyc(1'b0, 1'b0);
    chk("bit3 of 0x55 on line", o_tx[0], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async reset tx_out", o_tx[0], 1'b1);
    chk("async reset busy", o_busy[0], 1'b0);
    chk("async reset tx_ready", o_rdy[0], 1'b1);
    chk("async reset sel", o_sel[0], 2'b11);
    repeat (2) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    run_ticks(3, -1, 8'h00, 1'b0);
    cnt = 0;
    for (int i = 0; i < 3; i++) if (lg_tx[0][i] == 1'b1) cnt++;
    chk("no activity after reset", cnt, 3);
    chk("idle after reset", o_busy[0], 1'b0);

    // tx_valid and baud_tick together in IDLE
    wait_idle();
    tx_data = 8'h81;
    cyc(1'b1, 1'b1);
    chk("coincident accept busy", o_busy[0], 1'b1);
    chk("coincident accept ready", o_rdy[0], 1'b0);
    chk("coincident tick ignored", o_tx[0], 1'b1);
    run_ticks(12, -1, 8'h00, 1'b0);
    chk("start at following tick", lg_tx[0][0], 1'b0);

    // Back-to-back: tx_valid held high across frames
    wait_idle();
    tx_data = 8'h5A;
    run_ticks(26, -1, 8'h00, 1'b1);
    chk("b2b idle bit between frames", lg_tx[0][10], 1'b1);
    chk("b2b second start bit", lg_tx[0][11], 1'b0);
    run_ticks(14, -1, 8'h00, 1'b0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
